// File: rtl/fifo_rd_packetizer_if.sv
// Bundle for the fifo read port and the outgoing valid/ready stream.
//  master : packetizer view (drives fifo_read_en and the m_* stream outputs)
//  slave  : environment view (fifo model plus stream sink)
interface fifo_rd_packetizer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_read_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    output fifo_read_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    input  fifo_read_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_packetizer.sv
// Read-side fifo consumer. Pulls words from the fifo read port and presents
// them as a valid/ready stream, marking every PKT_LEN-th beat with m_last.
// A 2-entry buffer (head/tail) absorbs the fifo's 1-cycle read latency so the
// stream runs at 1 beat/cycle and never overflows when the sink stalls.
// Ports:
//  clk, reset_n   clock, async active-low reset
//  bus (master)   fifo_empty/fifo_data_out/fifo_underflow in, fifo_read_en out;
//                 m_valid/m_data/m_last out, m_ready in
//  pkt_count      completed packets, wrapping
//  err_underflow  sticky fifo_underflow flag
module fifo_rd_packetizer #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fifo_rd_packetizer_if.master bus,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 err_underflow
);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

  occ_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [BW-1:0]         beat_cnt;
  logic                  inflight;
  logic                  run;
  logic                  push, pop, m_valid_i, is_last;
  logic                  ld_head, head_from_tail, ld_tail;
  logic [2:0]            occ_sum;

  assign m_valid_i = (state != EMPTY);
  assign push      = inflight;
  assign pop       = m_valid_i & bus.m_ready;
  assign is_last   = (beat_cnt == BW'(PKT_LEN - 1));

  // Occupancy after this edge if a new read is not issued; a read is allowed
  // only while that leaves room for the word it will return next cycle.
  assign occ_sum = 3'(state) + 3'(inflight) - 3'(pop);

  // run holds reads off during reset and for the first cycle after release.
  assign bus.fifo_read_en = run & ~bus.fifo_empty & (occ_sum < 3'd2);
  assign bus.m_valid      = m_valid_i;
  assign bus.m_data       = head;
  assign bus.m_last       = m_valid_i & is_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ld_head        = 1'b0;
    head_from_tail = 1'b0;
    ld_tail        = 1'b0;
    case (state)
      EMPTY: if (push) begin
        state_nxt = ONE;
        ld_head   = 1'b1;
      end
      ONE: case ({push, pop})
        2'b10: begin state_nxt = TWO;   ld_tail = 1'b1; end
        2'b01:       state_nxt = EMPTY;
        2'b11:       ld_head   = 1'b1;
        default: ;
      endcase
      TWO: if (pop) begin
        // read gating keeps push-without-pop impossible here
        ld_head        = 1'b1;
        head_from_tail = 1'b1;
        if (push) ld_tail   = 1'b1;
        else      state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      inflight      <= 1'b0;
      run           <= 1'b0;
      beat_cnt      <= '0;
      pkt_count     <= '0;
      err_underflow <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= bus.fifo_read_en;
      if (ld_head) head <= head_from_tail ? tail : bus.fifo_data_out;
      if (ld_tail) tail <= bus.fifo_data_out;
      if (pop) begin
        if (is_last) begin
          beat_cnt  <= '0;
          pkt_count <= pkt_count + CNT_WIDTH'(1);
        end else begin
          beat_cnt  <= beat_cnt + BW'(1);
        end
      end
      if (bus.fifo_underflow) err_underflow <= 1'b1;
    end
  end
endmodule
